div_seq: RTL
============

Name: div_seq

Overview:
- Multi-cycle sequencer for the CPU's 32-bit DIV/DIVU unit.
- Sits beside the EX stage and is started by the decoded DIV/DIVU instruction.
- Runs a radix-2 restoring division, one quotient bit per cycle, and stalls the pipeline while busy.
- Hands {HI,LO} = {remainder, quotient} to the HI/LO write path; flushes (exceptions, branch kill) cancel it.

Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  EX stage holds a DIV/DIVU; held high until ready_o is seen
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU; sampled at accept
- opdata1_i  in  WIDTH  dividend (rs); sampled at accept
- opdata2_i  in  WIDTH  divisor (rt); sampled at accept
- annul_i  in  1  flush; cancels a pending or running division
- stall_o  out  1  pipeline stall request
- ready_o  out  1  result valid this cycle
- result_o  out  2*WIDTH  {remainder, quotient}

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, cnt=0, all internal registers cleared.
  - stall_o=0, ready_o=0, result_o=0.
- States: IDLE, DIVZERO, ON, END.
- IDLE:
  - Accept when start_i=1 and annul_i=0. Call the accept cycle t.
  - At accept, capture signed_i, original opdata1_i, sign of each operand, and absolute values (absolute only when signed_i=1, else raw).
  - Capture zflag = (opdata2_i==0). Clear cnt and the partial remainder.
  - Next state: DIVZERO if zflag and DIV_ZERO_FAST_EN is defined, else ON.
- ON, one iteration per cycle:
  - Shift {rem, dvd} left by one bit.
  - Trial subtract: rem - |divisor|. If the result is non-negative, keep it and set quotient bit = 1; else quotient bit = 0.
  - Increment cnt.
  - On the iteration with cnt==WIDTH-1, also compute the final result, register it to result_o, and go to END.
  - Net effect: ready_o first high in cycle t+WIDTH+1 (t+33 for WIDTH=32).
- Sign fix-up (signed only):
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. No trap, no special case.
- Zero divisor, both builds:
  - result_o = {original opdata1_i, all-ones}, overriding the iterative and fix-up results.
- DIVZERO:
  - Load the zero-divisor result into result_o and go to END.
  - Only reachable with DIV_ZERO_FAST_EN defined.
- END:
  - ready_o=1.
  - Go to IDLE when start_i=0 or annul_i=1; otherwise stay in END with ready_o held at 1.
  - A new accept cannot occur in the same cycle as END; back-to-back divisions re-enter through IDLE.
- stall_o, combinational:
  - 1 in IDLE when start_i & ~annul_i.
  - 1 in ON and in DIVZERO.
  - 0 in END and otherwise.
- annul_i:
  - In ON or DIVZERO: state becomes IDLE at the next edge and ready_o never asserts for that operation.
  - In IDLE: blocks the accept.
  - result_o keeps its previous value in all annul cases.
- result_o is only updated on completion and holds until the next completion or reset.
- Reset asserted mid-operation: immediate return to the reset state; no residual ready_o.
- Inputs opdata1_i, opdata2_i and signed_i are ignored outside the accept cycle.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined:
  - A zero divisor takes the IDLE→DIVZERO→END path.
  - ready_o in cycle t+2; stall_o high only in cycles t and t+1.
- Undefined:
  - The DIVZERO state is not built and a zero divisor runs all WIDTH iterations.
  - ready_o in cycle t+WIDTH+1.
  - result_o is identical to the defined build, {dividend, all-ones}.

Test Plan:
- DIVU 100/7, start at cycle t: stall_o=1 for t..t+32; ready_o=1 at t+33; result_o={32'd2, 32'd14}.
- DIV -7/2 (0xFFFFFFF9/0x00000002): result_o={0xFFFFFFFF, 0xFFFFFFFD}. DIV 7/-2: result_o={0x00000001, 0xFFFFFFFD}.
- DIV 0x80000000/0xFFFFFFFF: result_o={0x00000000, 0x80000000} at t+33, no hang.
- DIVU 0x12345678/0:
  - With DIV_ZERO_FAST_EN: ready_o at t+2, result_o={0x12345678, 0xFFFFFFFF}.
  - Without: same value at t+33.
- annul_i pulsed at t+10 during ON: state=IDLE at t+11; ready_o stays 0; result_o unchanged; a new start at t+12 completes at t+45 with the correct value.
- rst asserted at t+5 mid-division: stall_o, ready_o and result_o go to 0 immediately; after release, DIVU 9/3 gives {0, 3}.

Source files
------------

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module      : div_seq
// Description : Multi-cycle sequencer for the 32-bit DIV/DIVU unit.
//               Radix-2 restoring division, one quotient bit per cycle.
//               Returns {remainder, quotient} for the HI/LO write path and
//               holds the pipeline stall request while it is busy.
//               Optional macro DIV_ZERO_FAST_EN: a zero divisor finishes in
//               two cycles (IDLE -> DIVZERO -> END) instead of running the
//               full iteration count. The result value is the same either way.
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous, active-high reset
//               start_i    - DIV/DIVU present in EX, held until ready_o
//               signed_i   - 1 = DIV (two's complement), 0 = DIVU
//               opdata1_i  - dividend (rs), sampled at accept
//               opdata2_i  - divisor (rt), sampled at accept
//               annul_i    - flush; cancels a pending or running division
//               stall_o    - pipeline stall request
//               ready_o    - result valid this cycle
//               result_o   - {remainder, quotient}
// Revision    : 1.0 - initial release
// ============================================================================
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 annul_i,
    output logic                 stall_o,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   result_o
);

    localparam logic [1:0] c_IDLE    = 2'd0;
`ifdef DIV_ZERO_FAST_EN
    localparam logic [1:0] c_DIVZERO = 2'd1;
`endif
    localparam logic [1:0] c_ON      = 2'd2;
    localparam logic [1:0] c_END     = 2'd3;

    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_signed;
    logic               r_neg1;
    logic               r_neg2;
    logic               r_zero;
    logic [WIDTH-1:0]   r_op1;      // original dividend, needed for the zero-divisor result
    logic [WIDTH-1:0]   r_dvd;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   r_dvs;      // |divisor|
    logic [WIDTH-1:0]   r_rem;      // partial remainder
    logic [2*WIDTH-1:0] r_result;

    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_rem_nx;
    logic [WIDTH-1:0]   w_quo_nx;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [2*WIDTH-1:0] w_final;
    logic [2*WIDTH-1:0] w_zero_res;

    // Magnitudes are taken only for DIV; DIVU operands pass through raw.
    assign w_abs1 = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign w_abs2 = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // The shifted remainder needs one extra bit: it can reach 2*|divisor|-1.
    assign w_rem_sh = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
    // Low bits of the subtraction are exact whenever the trial succeeds.
    assign w_diff   = w_rem_sh[WIDTH-1:0] - r_dvs;
    assign w_rem_nx = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
    assign w_quo_nx = {r_dvd[WIDTH-2:0], w_ge};

    // Quotient negative when signs differ; remainder follows the dividend.
    assign w_quo_fix = (r_signed && (r_neg1 ^ r_neg2)) ? -w_quo_nx : w_quo_nx;
    assign w_rem_fix = (r_signed && r_neg1) ? -w_rem_nx : w_rem_nx;

    assign w_zero_res = {r_op1, {WIDTH{1'b1}}};
    assign w_final    = r_zero ? w_zero_res : {w_rem_fix, w_quo_fix};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_signed <= 1'b0;
            r_neg1   <= 1'b0;
            r_neg2   <= 1'b0;
            r_zero   <= 1'b0;
            r_op1    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start_i && !annul_i) begin
                        r_signed <= signed_i;
                        r_op1    <= opdata1_i;
                        r_neg1   <= opdata1_i[WIDTH-1];
                        r_neg2   <= opdata2_i[WIDTH-1];
                        r_dvd    <= w_abs1;
                        r_dvs    <= w_abs2;
                        r_zero   <= (opdata2_i == '0);
                        r_cnt    <= '0;
                        r_rem    <= '0;
`ifdef DIV_ZERO_FAST_EN
                        r_state  <= (opdata2_i == '0) ? c_DIVZERO : c_ON;
`else
                        r_state  <= c_ON;
`endif
                    end
                end
`ifdef DIV_ZERO_FAST_EN
                c_DIVZERO: begin
                    if (annul_i) begin
                        r_state  <= c_IDLE;
                    end else begin
                        r_result <= w_zero_res;
                        r_state  <= c_END;
                    end
                end
`endif
                c_ON: begin
                    if (annul_i) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_rem <= w_rem_nx;
                        r_dvd <= w_quo_nx;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == c_LAST_CNT) begin
                            r_result <= w_final;
                            r_state  <= c_END;
                        end
                    end
                end
                c_END: begin
                    // No accept from END; a new division re-enters via IDLE.
                    if (!start_i || annul_i) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_o = 1'b0;
        case (r_state)
            c_IDLE:    stall_o = start_i & ~annul_i;
`ifdef DIV_ZERO_FAST_EN
            c_DIVZERO: stall_o = 1'b1;
`endif
            c_ON:      stall_o = 1'b1;
            default:   stall_o = 1'b0;
        endcase
    end

    assign ready_o  = (r_state == c_END);
    assign result_o = r_result;

endmodule
`default_nettype wire
